// File: rtl/riscv_instruction_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master side produces symbolic requests and consumes encoded words.
interface riscv_instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [15:0] err_count;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_count
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_count
    );
endinterface

// File: rtl/riscv_instruction_encoder.sv
// Sequential RV32I encoder: symbolic op + registers + immediate in, packed
// instruction word tagged with a sequential program address out.
module riscv_instruction_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                          clk,
    input logic                          rst_n,
    riscv_instruction_encoder_if.slave   bus
);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_SLL  = 5'd2,  OP_SLT  = 5'd3,
        OP_SLTU  = 5'd4,  OP_XOR   = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
        OP_OR    = 5'd8,  OP_AND   = 5'd9,  OP_ADDI = 5'd10, OP_SLTI = 5'd11,
        OP_SLTIU = 5'd12, OP_XORI  = 5'd13, OP_ORI  = 5'd14, OP_ANDI = 5'd15,
        OP_SLLI  = 5'd16, OP_SRLI  = 5'd17, OP_SRAI = 5'd18, OP_JAL  = 5'd19
    } op_e;

    typedef enum logic [2:0] {
        FMT_BAD,
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_J
    } fmt_e;

    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_JAL = 7'h6F;

    logic [31:0] pc;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_addr_q;
    logic        err_q;
    logic [15:0] err_count_q;

    logic        accept;
    logic        legal;
    logic [31:0] word;
    fmt_e        fmt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        imm_i_ok;
    logic        imm_sh_ok;
    logic        imm_j_ok;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Range checks: the bits above the encodable field must all equal its sign bit.
    assign imm_i_ok  = (bus.in_imm[31:11] == '0) || (bus.in_imm[31:11] == '1);
    assign imm_sh_ok = (bus.in_imm[31:5] == '0);
    assign imm_j_ok  = ((bus.in_imm[31:20] == '0) || (bus.in_imm[31:20] == '1))
                       && !bus.in_imm[0];

    // Operation -> format and function fields; shift ops share funct3 with R-type.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        fmt    = FMT_BAD;
        funct3 = 3'd0;
        funct7 = 7'h00;
        case (op_e'(bus.in_op))
            OP_ADD:   fmt = FMT_R;
            OP_SUB:   begin fmt = FMT_R;  funct7 = 7'h20; end
            OP_SLL:   begin fmt = FMT_R;  funct3 = 3'd1; end
            OP_SLT:   begin fmt = FMT_R;  funct3 = 3'd2; end
            OP_SLTU:  begin fmt = FMT_R;  funct3 = 3'd3; end
            OP_XOR:   begin fmt = FMT_R;  funct3 = 3'd4; end
            OP_SRL:   begin fmt = FMT_R;  funct3 = 3'd5; end
            OP_SRA:   begin fmt = FMT_R;  funct3 = 3'd5; funct7 = 7'h20; end
            OP_OR:    begin fmt = FMT_R;  funct3 = 3'd6; end
            OP_AND:   begin fmt = FMT_R;  funct3 = 3'd7; end
            OP_ADDI:  fmt = FMT_I;
            OP_SLTI:  begin fmt = FMT_I;  funct3 = 3'd2; end
            OP_SLTIU: begin fmt = FMT_I;  funct3 = 3'd3; end
            OP_XORI:  begin fmt = FMT_I;  funct3 = 3'd4; end
            OP_ORI:   begin fmt = FMT_I;  funct3 = 3'd6; end
            OP_ANDI:  begin fmt = FMT_I;  funct3 = 3'd7; end
            OP_SLLI:  begin fmt = FMT_SH; funct3 = 3'd1; end
            OP_SRLI:  begin fmt = FMT_SH; funct3 = 3'd5; end
            OP_SRAI:  begin fmt = FMT_SH; funct3 = 3'd5; funct7 = 7'h20; end
            OP_JAL:   fmt = FMT_J;
            default:  fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        word  = '0;
        case (fmt)
            FMT_R: begin
                legal = 1'b1;
                word  = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, OPC_R};
            end
            FMT_I: begin
                legal = imm_i_ok;
                word  = {bus.in_imm[11:0], bus.in_rs1, funct3, bus.in_rd, OPC_I};
            end
            FMT_SH: begin
                legal = imm_sh_ok;
                word  = {funct7, bus.in_imm[4:0], bus.in_rs1, funct3, bus.in_rd, OPC_I};
            end
            FMT_J: begin
                legal = imm_j_ok;
                word  = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                         bus.in_imm[19:12], bus.in_rd, OPC_JAL};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= BASE_ADDR;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            err_q <= 1'b0;
            if (accept && legal) begin
                out_instr_q <= word;
                out_addr_q  <= pc;
                pc          <= pc + 32'd4;
                out_valid_q <= 1'b1;
            end else begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_q <= 1'b0;
                end
                if (accept) begin
                    err_q <= 1'b1;
                    if (err_count_q != 16'hFFFF) begin
                        err_count_q <= err_count_q + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_instruction_encoder.sv
// Directed bench for riscv_instruction_encoder: hand-encoded words, illegal
// requests, backpressure, mid-stream reset and error-count saturation.
module tb_riscv_instruction_encoder;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, XOR_ = 5'd5,
                           OR_ = 5'd8, AND_ = 5'd9, ADDI = 5'd10, SLLI = 5'd16,
                           SRAI = 5'd18, JAL = 5'd19;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    riscv_instruction_encoder_if bus ();

    riscv_instruction_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] instr, input logic [31:0] addr);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".instr"}, bus.out_instr, instr);
        check({tag, ".addr"},  bus.out_addr,  addr);
    endtask

    task automatic expect_err(input string tag, input logic e, input logic [15:0] cnt,
                              input logic ov);
        check({tag, ".err"},   {31'd0, bus.err}, {31'd0, e});
        check({tag, ".count"}, {16'd0, bus.err_count}, {16'd0, cnt});
        check({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        drive(ADD, 5'd0, 5'd0, 5'd0, 32'd0);
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        check("rst.valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.instr", bus.out_instr, 32'd0);
        check("rst.addr",  bus.out_addr,  32'd0);
        check("rst.err",   {31'd0, bus.err}, 32'd0);
        check("rst.count", {16'd0, bus.err_count}, 32'd0);
        check("rst.ready", {31'd0, bus.in_ready}, 32'd1);

        // Illegal requests: out-of-range I immediate, odd JAL offset, unused op.
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        expect_err("ill_addi", 1'b1, 16'd1, 1'b0);
        drive(JAL, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        expect_err("ill_jal", 1'b1, 16'd2, 1'b0);
        drive(5'd25, 5'd1, 5'd0, 5'd0, 32'd0);
        tick();
        expect_err("ill_op", 1'b1, 16'd3, 1'b0);

        // Back-to-back legal words; pc untouched by the illegal requests.
        drive(ADD, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
        tick();
        check("add.err", {31'd0, bus.err}, 32'd0);
        expect_word("add", 32'h0020_81B3, 32'h00);
        drive(SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        expect_word("sub", 32'h4020_81B3, 32'h04);
        drive(ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        tick();
        expect_word("addi_m1", 32'hFFF0_0093, 32'h08);
        drive(SRAI, 5'd5, 5'd6, 5'd0, 32'd3);
        tick();
        expect_word("srai", 32'h4033_5293, 32'h0C);
        drive(JAL, 5'd1, 5'd7, 5'd9, 32'd8);
        tick();
        expect_word("jal8", 32'h0080_00EF, 32'h10);
        drive(SLL, 5'd4, 5'd5, 5'd6, 32'd0);
        tick();
        expect_word("sll", 32'h0062_9233, 32'h14);
        drive(AND_, 5'd31, 5'd31, 5'd31, 32'h1234_5678);
        tick();
        expect_word("and", 32'h01FF_FFB3, 32'h18);
        drive(ADDI, 5'd2, 5'd3, 5'd31, 32'd2047);
        tick();
        expect_word("addi_max", 32'h7FF1_8113, 32'h1C);
        drive(ADDI, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
        tick();
        expect_word("addi_min", 32'h8000_0013, 32'h20);
        drive(SLLI, 5'd1, 5'd1, 5'd0, 32'd31);
        tick();
        expect_word("slli31", 32'h01F0_9093, 32'h24);
        drive(JAL, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        tick();
        expect_word("jal_m4", 32'hFFDF_F06F, 32'h28);

        // Illegal accept while the previous word drains.
        drive(SLLI, 5'd1, 5'd1, 5'd0, 32'd32);
        tick();
        expect_err("ill_sh32", 1'b1, 16'd4, 1'b0);
        drive(JAL, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
        tick();
        expect_err("ill_jal_rng", 1'b1, 16'd5, 1'b0);
        idle();
        tick();
        expect_err("err_clear", 1'b0, 16'd5, 1'b0);

        // Backpressure: first word holds, second waits for out_ready.
        bus.out_ready = 1'b0;
        drive(XOR_, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        expect_word("bp_first", 32'h0031_40B3, 32'h2C);
        check("bp_ready0", {31'd0, bus.in_ready}, 32'd0);
        drive(OR_, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        expect_word("bp_hold1", 32'h0031_40B3, 32'h2C);
        tick();
        expect_word("bp_hold2", 32'h0031_40B3, 32'h2C);
        check("bp_ready1", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_comb", {31'd0, bus.in_ready}, 32'd1);
        tick();
        expect_word("bp_second", 32'h0031_60B3, 32'h30);
        idle();
        tick();
        check("bp_drain", {31'd0, bus.out_valid}, 32'd0);

        // Reset with a word pending.
        bus.out_ready = 1'b0;
        drive(ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        expect_word("pre_rst", 32'h0020_81B3, 32'h34);
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        check("mid_rst.valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst.count", {16'd0, bus.err_count}, 32'd0);
        check("mid_rst.addr",  bus.out_addr, 32'd0);
        check("mid_rst.instr", bus.out_instr, 32'd0);
        bus.out_ready = 1'b1;
        drive(ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        expect_word("post_rst", 32'h0020_81B3, 32'h00);

        // Error-count saturation: one illegal accept per cycle.
        drive(5'd31, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 70000; i++) begin
            if (bus.err_count == 16'hFFFE) break;
            tick();
        end
        check("sat.near", {16'd0, bus.err_count}, 32'h0000_FFFE);
        tick();
        check("sat.reach", {16'd0, bus.err_count}, 32'h0000_FFFF);
        tick();
        tick();
        expect_err("sat.hold", 1'b1, 16'hFFFF, 1'b0);
        idle();
        tick();
        expect_err("sat.idle", 1'b0, 16'hFFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_instruction_encoder.md
# riscv_instruction_encoder

Sequential RV32I instruction encoder. It is the inverse of the decode stage. It accepts symbolic operations (operation code, register indices, immediate) over a valid/ready handshake and range-checks the immediate. It emits the packed 32-bit instruction word, tagged with a sequential program address, through a registered valid/ready output. It feeds instruction-memory loaders and generates stimulus for the decode-stage benches.

## Interface
- BASE_ADDR, 32'h0000_0000: address assigned to the first emitted word after reset.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept; combinational: !out_valid || out_ready
- in_op  in  5  operation code (list below)
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, two's complement, byte offset for JAL
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  32  program address of out_instr
- err  out  1  one-cycle pulse: the previous accepted request was illegal
- err_count  out  16  illegal-request count, saturates at 16'hFFFF

## Operation
- Operation codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 ADDI, 11 SLTI, 12 SLTIU, 13 XORI, 14 ORI, 15 ANDI, 16 SLLI, 17 SRLI, 18 SRAI.
  - 19 JAL.
  - 20–31 illegal.
- R-type (opcode 7'h33): funct3 follows ADD/SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL/SRA=5, OR=6, AND=7.
  - funct7 = 7'h20 for SUB and SRA, else 7'h00.
  - in_imm is ignored.
- I-type ALU (opcode 7'h13): funct3 as the R-type equivalents.
  - in_imm must sign-extend from bit 11 (-2048..2047); instr[31:20] = in_imm[11:0].
  - in_rs2 is ignored.
- Shift-immediate: in_imm must be 0..31.
  - instr[24:20] = in_imm[4:0].
  - instr[31:25] = 7'h20 for SRAI, else 7'h00.
- JAL (opcode 7'h6F): in_imm must sign-extend from bit 20 with in_imm[0] = 0.
  - instr[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]}.
  - in_rs1 and in_rs2 are ignored.
- Ignored fields must never affect out_instr.
- Accept = in_valid && in_ready.
- Legal accept:
  - out_instr <= encoding, out_addr <= pc, pc <= pc + 4, out_valid <= 1.
  - pc wraps modulo 2^32.
- Illegal accept (bad op or out-of-range immediate):
  - The request is consumed and no word is emitted.
  - pc is unchanged.
  - err <= 1 for one cycle; err_count increments, saturating.
- Output drain: if out_ready && out_valid and there is no legal accept that cycle, out_valid <= 0.
- Output stability: out_instr and out_addr hold stable while out_valid && !out_ready.
- Reset values:
  - out_valid = 0, out_instr = 0, err = 0, err_count = 0.
  - out_addr = BASE_ADDR, pc = BASE_ADDR.

## Timing
- Latency: 1 cycle from accept edge to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Simultaneous drain and legal accept: the new word replaces the old one and out_valid stays 1 with no bubble.
- Simultaneous drain and illegal accept: out_valid <= 0 and err <= 1.
- Backpressure: out_valid && !out_ready forces in_ready = 0. Requests are held by the producer, not dropped.
- err is asserted the cycle after the illegal accept and deasserts one cycle later unless another illegal accept occurs.
- Reset mid-stream: the pending output word is discarded, pc returns to BASE_ADDR, err_count clears.
- in_ready is combinational from out_valid and out_ready only, with no path from in_valid.

## Test plan
- ADD rd=3, rs1=1, rs2=2 followed by SUB with the same registers, out_ready=1:
  - Words 0x002081B3 then 0x402081B3.
  - out_addr 0x0 then 0x4; no bubble.
- ADDI rd=1, rs1=0, imm=-1 -> 0xFFF00093.
- SRAI rd=5, rs1=6, imm=3 -> 0x40335293.
- JAL rd=1, imm=8 -> 0x008000EF.
- Illegal requests: ADDI imm=2048, then JAL imm=3, then op=25.
  - Each produces an err pulse and no out_valid.
  - err_count ends at 3; the next legal word still gets address 0x0.
- Backpressure: out_ready=0 while two legal ops are offered.
  - The first word is held stable and in_ready=0.
  - After out_ready rises, the second word follows in the next cycle with address +4.
- Reset: assert rst_n=0 while out_valid=1.
  - The following cycle shows out_valid=0, err_count=0, out_addr=BASE_ADDR.
- err_count saturation: force or preload err_count near 16'hFFFF, then issue further illegal requests; the count stays at 16'hFFFF.
